// File: rtl/membus_arbiter_n.sv
// N-channel memory bus arbiter: round-robin or fixed-priority grant onto one registered
// request port, with a tag FIFO that routes in-order responses back to the issuing channel.

module membus_arb_ch_n (
    input  logic grant_hit,
    input  logic accept,
    input  logic head_hit,
    input  logic pop,
    output logic req_ready,
    output logic resp_valid
);
    assign req_ready  = grant_hit & accept;
    assign resp_valid = head_hit & pop;
endmodule

module membus_arbiter_n #(
    parameter int NUM_CH    = 2,
    parameter int OUT_DEPTH = 4,
    parameter int ARB_MODE  = 0,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req_valid,
    output logic [NUM_CH-1:0]        ch_req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
    input  logic [NUM_CH-1:0]        ch_req_wen,
    input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
    output logic [NUM_CH-1:0]        ch_resp_valid,
    output logic                     ch_resp_error,
    output logic [ADDR_W-1:0]        ch_resp_addr,
    output logic [DATA_W-1:0]        ch_resp_rdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [ADDR_W-1:0]        mem_req_addr,
    output logic                     mem_req_wen,
    output logic [DATA_W-1:0]        mem_req_wdata,
    input  logic                     mem_resp_valid,
    input  logic                     mem_resp_error,
    input  logic [ADDR_W-1:0]        mem_resp_addr,
    input  logic [DATA_W-1:0]        mem_resp_rdata,
    output logic                     err_unexpected
);
    localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);
    localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NUM_CH - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wen;
        logic [DATA_W-1:0] wdata;
    } req_t;

    req_t             req_q, req_sel;
    logic             req_valid_q;
    logic [TAG_W-1:0] last_q, grant, head_tag;
    logic [TAG_W-1:0] tag_mem [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             slot_free, cap_ok, accept, pop, unexpected;

    // Round-robin scan starts one past the last winner and wraps.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_CH-1:0] v,
                                                 input logic [TAG_W-1:0] l);
        logic [TAG_W-1:0] r;
        logic             hit;
        int               idx;
        r   = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(l) + 1 + k) % NUM_CH;
            if (!hit && v[idx]) begin
                r   = TAG_W'(idx);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [TAG_W-1:0] fp_pick(input logic [NUM_CH-1:0] v);
        logic [TAG_W-1:0] r;
        logic             hit;
        r   = '0;
        hit = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!hit && v[k]) begin
                r   = TAG_W'(k);
                hit = 1'b1;
            end
        end
        return r;
    endfunction

    assign grant = (ARB_MODE == 1) ? fp_pick(ch_req_valid) : rr_pick(ch_req_valid, last_q);

    always_comb begin
        req_sel       = '0;
        req_sel.addr  = ch_req_addr[grant*ADDR_W +: ADDR_W];
        req_sel.wen   = ch_req_wen[grant];
        req_sel.wdata = ch_req_wdata[grant*DATA_W +: DATA_W];
    end

    // A response popping this cycle frees a slot for a same-cycle accept.
    assign slot_free  = !req_valid_q | mem_req_ready;
    assign cap_ok     = (cnt_q < DEPTH_C) | mem_resp_valid;
    assign accept     = !reset & (|ch_req_valid) & slot_free & cap_ok;
    assign pop        = !reset & mem_resp_valid & (cnt_q != '0);
    assign unexpected = mem_resp_valid & (cnt_q == '0);
    assign head_tag   = tag_mem[rd_ptr];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        membus_arb_ch_n u_ch (
            .grant_hit (grant == TAG_W'(i)),
            .accept    (accept),
            .head_hit  (head_tag == TAG_W'(i)),
            .pop       (pop),
            .req_ready (ch_req_ready[i]),
            .resp_valid(ch_resp_valid[i])
        );
    end

    assign ch_resp_error  = mem_resp_error;
    assign ch_resp_addr   = mem_resp_addr;
    assign ch_resp_rdata  = mem_resp_rdata;
    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = req_q.addr;
    assign mem_req_wen    = req_q.wen;
    assign mem_req_wdata  = req_q.wdata;
    assign err_unexpected = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            last_q      <= LAST_RST;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                req_q       <= req_sel;
                req_valid_q <= 1'b1;
                wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (ARB_MODE == 0) last_q <= grant;
            end else if (req_valid_q && mem_req_ready) begin
                req_valid_q <= 1'b0;
            end
            if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (unexpected) err_q <= 1'b1;
        end
    end

    // Tag storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (accept) tag_mem[wr_ptr] <= grant;
    end
endmodule
